// File: rtl/wb_cmd_master_if.sv
// Byte-stream command/response channels plus the Wishbone single-transfer bus.
// The master modport is the wb_cmd_master side; slave is the host and bus side.
interface wb_cmd_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] m_wb_addr;
  logic [31:0] m_wb_dat_o;
  logic [31:0] m_wb_dat_i;
  logic        m_wb_we;
  logic [3:0]  m_wb_sel;
  logic        m_wb_cyc;
  logic        m_wb_stb;
  logic        m_wb_ack;
  logic        m_wb_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, m_wb_dat_i, m_wb_ack, m_wb_err,
    output rx_ready, tx_data, tx_valid, m_wb_addr, m_wb_dat_o, m_wb_we,
           m_wb_sel, m_wb_cyc, m_wb_stb
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, m_wb_dat_i, m_wb_ack, m_wb_err,
    input  rx_ready, tx_data, tx_valid, m_wb_addr, m_wb_dat_o, m_wb_we,
           m_wb_sel, m_wb_cyc, m_wb_stb
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone single-transfer master driven by opcode/address/data byte frames.
// Answers every command with a status byte, followed by 4 data bytes on a good read.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  wb_cmd_master_if.master bus,
  output logic busy
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, BUS, RESP_STATUS, RESP_DATA
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdat;
  logic        r_is_wr;
  logic [7:0]  r_status;
  logic [TW-1:0] r_tmo;

  logic          w_rx_fire;
  logic          w_tx_fire;
  logic          w_op_ok;
  logic [TW-1:0] w_tmo_inc;
  logic          w_tmo_hit;
  logic          w_term;

  assign w_rx_fire = bus.rx_valid && bus.rx_ready;
  assign w_tx_fire = bus.tx_valid && bus.tx_ready;
  assign w_op_ok   = (bus.rx_data == 8'h52) || (bus.rx_data == 8'h57);
  assign w_tmo_inc = r_tmo + TW'(1);
  // The counter value after this cycle's increment reaching the limit aborts,
  // so the strobe is held for exactly TIMEOUT_CYCLES bus cycles.
  assign w_tmo_hit = (w_tmo_inc == TW'(TIMEOUT_CYCLES));
  assign w_term    = bus.m_wb_ack || bus.m_wb_err || w_tmo_hit;

  assign bus.rx_ready   = (r_state == IDLE) || (r_state == ADDR) || (r_state == WDATA);
  assign bus.m_wb_cyc   = (r_state == BUS);
  assign bus.m_wb_stb   = (r_state == BUS);
  assign bus.m_wb_we    = (r_state == BUS) && r_is_wr;
  assign bus.m_wb_sel   = (r_state == BUS) ? 4'hF : 4'h0;
  assign bus.m_wb_addr  = r_addr;
  assign bus.m_wb_dat_o = r_wdat;
  assign bus.tx_valid   = (r_state == RESP_STATUS) || (r_state == RESP_DATA);
  assign busy           = (r_state != IDLE);

  always_comb begin
    bus.tx_data = 8'h00;
    case (r_state)
      RESP_STATUS: bus.tx_data = r_status;
      RESP_DATA:   bus.tx_data = r_rdat[31:24];
      default:     bus.tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rx_fire) begin
          w_state_nxt = w_op_ok ? ADDR : RESP_STATUS;
        end
      end
      ADDR: begin
        if (w_rx_fire && (r_cnt == 2'd3)) begin
          w_state_nxt = r_is_wr ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (w_rx_fire && (r_cnt == 2'd3)) begin
          w_state_nxt = BUS;
        end
      end
      BUS: begin
        if (w_term) begin
          w_state_nxt = RESP_STATUS;
        end
      end
      RESP_STATUS: begin
        if (w_tx_fire) begin
          w_state_nxt = ((r_status == 8'h00) && !r_is_wr) ? RESP_DATA : IDLE;
        end
      end
      RESP_DATA: begin
        if (w_tx_fire && (r_cnt == 2'd3)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte counter wraps 3 -> 0, so it is already clear for the next phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 2'd0;
      r_addr   <= 32'h0;
      r_wdat   <= 32'h0;
      r_rdat   <= 32'h0;
      r_is_wr  <= 1'b0;
      r_status <= 8'h00;
      r_tmo    <= '0;
    end else begin
      r_tmo <= '0;
      case (r_state)
        IDLE: begin
          if (w_rx_fire) begin
            r_cnt    <= 2'd0;
            r_is_wr  <= (bus.rx_data == 8'h57);
            r_status <= w_op_ok ? 8'h00 : 8'h03;
          end
        end
        ADDR: begin
          if (w_rx_fire) begin
            r_addr <= {r_addr[23:0], bus.rx_data};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        WDATA: begin
          if (w_rx_fire) begin
            r_wdat <= {r_wdat[23:0], bus.rx_data};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        BUS: begin
          if (bus.m_wb_err) begin
            r_status <= 8'h01;
          end else if (bus.m_wb_ack) begin
            r_status <= 8'h00;
            if (!r_is_wr) begin
              r_rdat <= bus.m_wb_dat_i;
            end
          end else if (w_tmo_hit) begin
            r_status <= 8'h02;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end
        RESP_DATA: begin
          if (w_tx_fire) begin
            r_rdat <= {r_rdat[23:0], 8'h00};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized self-checking bench: frames are driven, a Wishbone slave model
// answers, and responses are compared with a frame-level reference model.
module tb_wb_cmd_master;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  wb_cmd_master_if bus_if();

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Slave behaviour: mode 0 ack, 1 err, 2 err+ack, 3 never answer
  int          sl_mode  = 0;
  int          sl_delay = 0;
  logic [31:0] sl_rdata = 32'h0;
  int          bus_cnt  = 0;
  int          stb_cyc  = 0;
  int          hold_err = 0;
  logic [31:0] cap_addr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  initial begin
    int n;
    n = 0;
    bus_if.m_wb_ack   = 1'b0;
    bus_if.m_wb_err   = 1'b0;
    bus_if.m_wb_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.m_wb_ack = 1'b0;
      bus_if.m_wb_err = 1'b0;
      if (bus_if.m_wb_cyc && bus_if.m_wb_stb) begin
        n++;
        stb_cyc++;
        if (n == 1) begin
          bus_cnt++;
          cap_addr = bus_if.m_wb_addr;
          cap_dat  = bus_if.m_wb_dat_o;
          cap_we   = bus_if.m_wb_we;
          cap_sel  = bus_if.m_wb_sel;
        end else if (bus_if.m_wb_addr != cap_addr || bus_if.m_wb_dat_o != cap_dat ||
                     bus_if.m_wb_we != cap_we) begin
          hold_err++;
        end
        if (sl_mode != 3 && n > sl_delay) begin
          bus_if.m_wb_ack = (sl_mode == 0) || (sl_mode == 2);
          bus_if.m_wb_err = (sl_mode == 1) || (sl_mode == 2);
        end
      end else begin
        n = 0;
      end
      bus_if.m_wb_dat_i = bus_if.m_wb_ack ? sl_rdata : $urandom();
    end
  end

  // Response sink with random back-pressure and a forced-stall request
  logic [7:0] rsp_q[$];
  int         force_stall = 0;
  initial begin
    logic       stalled;
    logic [7:0] stall_data;
    stalled = 1'b0;
    stall_data = 8'h00;
    bus_if.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled) begin
        check_eq("tx_hold_valid", bus_if.tx_valid, 1'b1);
        check_eq("tx_hold_data", bus_if.tx_data, stall_data);
      end
      if (bus_if.tx_valid && bus_if.tx_ready) rsp_q.push_back(bus_if.tx_data);
      stalled    = bus_if.tx_valid && !bus_if.tx_ready;
      stall_data = bus_if.tx_data;
      @(posedge clk);
      #1;
      if (force_stall > 0 && bus_if.tx_valid) begin
        bus_if.tx_ready = 1'b0;
        force_stall--;
      end else begin
        bus_if.tx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = bus_if.rx_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'($urandom());
    ok = acc;
  endtask

  task automatic send_frame(input int kind, input logic [7:0] badop,
                            input logic [31:0] addr, input logic [31:0] wdat, output bit all_ok);
    logic [7:0] fr[$];
    bit ok;
    fr.push_back(kind == 0 ? 8'h52 : (kind == 1 ? 8'h57 : badop));
    if (kind != 2) for (int i = 3; i >= 0; i--) fr.push_back(addr[i*8 +: 8]);
    if (kind == 1) for (int i = 3; i >= 0; i--) fr.push_back(wdat[i*8 +: 8]);
    all_ok = 1'b1;
    foreach (fr[i]) begin
      send_byte(fr[i], ok);
      if (!ok) all_ok = 1'b0;
    end
  endtask

  // kind: 0 read, 1 write, 2 bad opcode
  task automatic run_txn(input int kind, input logic [7:0] badop, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [31:0] rdat,
                         input int mode, input int delay, input string nm);
    logic [7:0] exp_q[$];
    logic [7:0] st;
    bit  all_ok;
    int  guard;
    int  rdy_viol;
    sl_mode  = mode;
    sl_delay = delay;
    sl_rdata = rdat;
    bus_cnt  = 0;
    stb_cyc  = 0;
    hold_err = 0;
    rsp_q.delete();
    send_frame(kind, badop, addr, wdat, all_ok);
    check_eq({nm, "_rx_accept"}, all_ok, 1'b1);
    guard = 0;
    rdy_viol = 0;
    while (busy && guard < 300) begin
      if (bus_if.rx_ready) rdy_viol++;
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq({nm, "_done"}, busy, 1'b0);
    check_eq({nm, "_rx_blocked"}, rdy_viol, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    // Reference model: status from slave behaviour, data only on a good read
    if (kind == 2)                     st = 8'h03;
    else if (mode == 1 || mode == 2)   st = 8'h01;
    else if (mode == 0)                st = 8'h00;
    else                               st = 8'h02;
    exp_q.push_back(st);
    if (kind == 0 && st == 8'h00) for (int i = 3; i >= 0; i--) exp_q.push_back(rdat[i*8 +: 8]);
    check_eq({nm, "_rsp_len"}, rsp_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < rsp_q.size()) check_eq({nm, "_rsp_byte"}, rsp_q[i], exp_q[i]);
    check_eq({nm, "_bus_cnt"}, bus_cnt, (kind == 2) ? 0 : 1);
    if (kind != 2) begin
      check_eq({nm, "_addr"}, cap_addr, addr);
      check_eq({nm, "_we"}, cap_we, (kind == 1) ? 1'b1 : 1'b0);
      check_eq({nm, "_sel"}, cap_sel, 4'hF);
      check_eq({nm, "_stb_cycles"}, stb_cyc, (mode == 3) ? TMO : delay + 1);
      check_eq({nm, "_bus_hold"}, hold_err, 0);
      if (kind == 1) check_eq({nm, "_dat_o"}, cap_dat, wdat);
    end
  endtask

  initial begin
    int          kind, mode, guard;
    logic [7:0]  badop;
    bit          all_ok;
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rx_ready", bus_if.rx_ready, 1'b1);
    check_eq("rst_cyc", bus_if.m_wb_cyc, 1'b0);
    check_eq("rst_stb", bus_if.m_wb_stb, 1'b0);
    check_eq("rst_we", bus_if.m_wb_we, 1'b0);
    check_eq("rst_sel", bus_if.m_wb_sel, 4'h0);
    check_eq("rst_addr", bus_if.m_wb_addr, 32'h0);
    check_eq("rst_dat_o", bus_if.m_wb_dat_o, 32'h0);
    check_eq("rst_tx_valid", bus_if.tx_valid, 1'b0);
    check_eq("rst_tx_data", bus_if.tx_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_txn(1, 8'h00, 32'h40000010, 32'hDEADBEEF, 32'h0, 0, 2, "wr_ack2");
    run_txn(0, 8'h00, 32'h00010004, 32'h0, 32'h12345678, 0, 0, "rd_ack");
    run_txn(0, 8'h00, 32'h00010008, 32'h0, 32'hCAFEF00D, 2, 1, "rd_err_ack");
    run_txn(0, 8'h00, 32'h0000000C, 32'h0, 32'h11111111, 3, 0, "rd_timeout");
    run_txn(2, 8'h41, 32'h0, 32'h0, 32'h0, 0, 0, "bad_op");
    force_stall = 5;
    run_txn(0, 8'h00, 32'hA5A50000, 32'h0, 32'h89ABCDEF, 0, 1, "rd_stall");

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 5) ? 0 : ((kind < 9) ? 1 : 2);
      mode = $urandom_range(0, 4);
      if (mode == 4) mode = 0;
      badop = 8'($urandom());
      if (badop == 8'h52 || badop == 8'h57) badop = 8'h00;
      if ($urandom_range(0, 3) == 0) force_stall = $urandom_range(1, 4);
      run_txn(kind, badop, $urandom(), $urandom(), $urandom(), mode, $urandom_range(0, 4), "rand");
    end

    // Reset while a read is stuck on the bus
    sl_mode = 3;
    rsp_q.delete();
    send_frame(0, 8'h00, 32'h00002000, 32'h0, all_ok);
    check_eq("rst_mid_rx_accept", all_ok, 1'b1);
    guard = 0;
    while (!bus_if.m_wb_stb && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("rst_mid_stb_seen", bus_if.m_wb_stb, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid_cyc", bus_if.m_wb_cyc, 1'b0);
    check_eq("rst_mid_stb", bus_if.m_wb_stb, 1'b0);
    check_eq("rst_mid_tx_valid", bus_if.tx_valid, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_rx_ready", bus_if.rx_ready, 1'b1);
    repeat (TMO + 4) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_mid_no_rsp", rsp_q.size(), 0);
    run_txn(0, 8'h00, 32'h00002004, 32'h0, 32'h0BADF00D, 0, 0, "post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
